// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: default base
// address, register offsets and the interrupt state machine encoding.
package timer_pkg;

   localparam logic [31:0] DEFAULT_TIMER_BASE = 32'h0000_4000;

   localparam logic [31:0] OFF_MTIME_LO    = 32'h0000_0000;
   localparam logic [31:0] OFF_MTIME_HI    = 32'h0000_0004;
   localparam logic [31:0] OFF_MTIMECMP_LO = 32'h0000_0008;
   localparam logic [31:0] OFF_MTIMECMP_HI = 32'h0000_000C;
   localparam logic [31:0] OFF_CTRL        = 32'h0000_0010;
   localparam logic [31:0] OFF_PRESCALE    = 32'h0000_0014;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      DISARMED  = 2'd0,
      ARMED     = 2'd1,
      PENDING   = 2'd2,
      INSERVICE = 2'd3
   } timer_state_t;

endpackage

// File: rtl/timer_counter.sv
// Prescaler plus free-running 64-bit mtime counter. A tick is produced
// whenever the prescale counter reaches the programmed prescale value;
// bus loads of either mtime half override a tick in the same cycle.
module timer_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [7:0]  prescale,
   input  logic        clear_prescale,
   input  logic        load_lo,
   input  logic        load_hi,
   input  logic [31:0] load_data,
   output logic        tick,
   output logic [63:0] mtime
);

   logic [7:0] prescale_count;

   assign tick = enable && (prescale_count == prescale);

   // Prescale counter: counts up while enabled, wraps on tick, cleared by config writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_count <= 8'd0;
      end else if (clear_prescale) begin
         prescale_count <= 8'd0;
      end else if (tick) begin
         prescale_count <= 8'd0;
      end else if (enable) begin
         prescale_count <= prescale_count + 8'd1;
      end
   end

   // mtime: a load replaces only its own half, otherwise advance on tick and wrap silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime <= 64'd0;
      end else if (load_lo) begin
         mtime[31:0] <= load_data;
      end else if (load_hi) begin
         mtime[63:32] <= load_data;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: register decode, compare logic and the
// interrupt handshake FSM (DISARMED/ARMED/PENDING/INSERVICE). The
// interrupt request is a flop so no input reaches it combinationally.
module machine_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] TIMER_BASE = DEFAULT_TIMER_BASE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        busWriteEnable,
   input  logic [31:0] busAddress,
   input  logic [31:0] busWriteData,
   output logic [31:0] busReadData,
   input  logic        trapTaken,
   input  logic        trapReturn,
   output logic        timerInterrupt
);

   logic         sel_mtime_lo, sel_mtime_hi, sel_cmp_lo, sel_cmp_hi, sel_ctrl, sel_prescale;
   logic         wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_prescale;
   logic         ctrl_enable;
   logic [7:0]   prescale;
   logic [63:0]  mtimecmp;
   logic [63:0]  mtimecmp_written;
   logic [63:0]  mtime;
   logic         tick;
   logic         compare_true;
   logic         compare_after_write;
   timer_state_t state, state_next;

   assign sel_mtime_lo = (busAddress == TIMER_BASE + OFF_MTIME_LO);
   assign sel_mtime_hi = (busAddress == TIMER_BASE + OFF_MTIME_HI);
   assign sel_cmp_lo   = (busAddress == TIMER_BASE + OFF_MTIMECMP_LO);
   assign sel_cmp_hi   = (busAddress == TIMER_BASE + OFF_MTIMECMP_HI);
   assign sel_ctrl     = (busAddress == TIMER_BASE + OFF_CTRL);
   assign sel_prescale = (busAddress == TIMER_BASE + OFF_PRESCALE);

   assign wr_mtime_lo = busWriteEnable && sel_mtime_lo;
   assign wr_mtime_hi = busWriteEnable && sel_mtime_hi;
   assign wr_cmp_lo   = busWriteEnable && sel_cmp_lo;
   assign wr_cmp_hi   = busWriteEnable && sel_cmp_hi;
   assign wr_ctrl     = busWriteEnable && sel_ctrl;
   assign wr_prescale = busWriteEnable && sel_prescale;

   timer_counter u_counter (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (ctrl_enable),
      .prescale       (prescale),
      .clear_prescale (wr_ctrl || wr_prescale),
      .load_lo        (wr_mtime_lo),
      .load_hi        (wr_mtime_hi),
      .load_data      (busWriteData),
      .tick           (tick),
      .mtime          (mtime)
   );

   // Compare on registered values; the second form previews a compare-register write
   always_comb begin
      mtimecmp_written = mtimecmp;
      if (wr_cmp_lo) begin
         mtimecmp_written[31:0] = busWriteData;
      end else if (wr_cmp_hi) begin
         mtimecmp_written[63:32] = busWriteData;
      end
      compare_true        = ctrl_enable && (mtime >= mtimecmp);
      compare_after_write = ctrl_enable && (mtime >= mtimecmp_written);
   end

   // Configuration registers: enable bit, prescale value and 64-bit compare value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_enable <= 1'b0;
         prescale    <= 8'd0;
         mtimecmp    <= MTIMECMP_RESET;
      end else begin
         if (wr_ctrl) begin
            ctrl_enable <= busWriteData[0];
         end
         if (wr_prescale) begin
            prescale <= busWriteData[7:0];
         end
         if (wr_cmp_lo || wr_cmp_hi) begin
            mtimecmp <= mtimecmp_written;
         end
      end
   end

   // Next-state logic; disabling overrides everything, trapTaken beats a compare rewrite
   always_comb begin
      state_next = state;
      if (wr_ctrl && !busWriteData[0]) begin
         state_next = DISARMED;
      end else begin
         case (state)
            DISARMED:  if (wr_ctrl) state_next = ARMED;
            ARMED:     if (compare_true) state_next = PENDING;
            PENDING: begin
               if (trapTaken) begin
                  state_next = INSERVICE;
               end else if ((wr_cmp_lo || wr_cmp_hi) && !compare_after_write) begin
                  state_next = ARMED;
               end
            end
            INSERVICE: if (trapReturn) state_next = ARMED;
            default:   state_next = DISARMED;
         endcase
      end
   end

   // State register plus interrupt flop decoded from the next state so it tracks PENDING exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= DISARMED;
         timerInterrupt <= 1'b0;
      end else begin
         state          <= state_next;
         timerInterrupt <= (state_next == PENDING);
      end
   end

   // Read mux: exact address match only, unmapped addresses read as zero
   always_comb begin
      busReadData = 32'd0;
      if (sel_mtime_lo) begin
         busReadData = mtime[31:0];
      end else if (sel_mtime_hi) begin
         busReadData = mtime[63:32];
      end else if (sel_cmp_lo) begin
         busReadData = mtimecmp[31:0];
      end else if (sel_cmp_hi) begin
         busReadData = mtimecmp[63:32];
      end else if (sel_ctrl) begin
         busReadData = {31'd0, ctrl_enable};
      end else if (sel_prescale) begin
         busReadData = {24'd0, prescale};
      end
   end

endmodule

// File: doc/machine_timer.md
MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL use that one clock and reset.
REQ-002 clk  input  1  core clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 busWriteEnable  input  1  data-memory store strobe, qualified by address decode.
REQ-005 busAddress  input  32  byte address of the load/store.
REQ-006 busWriteData  input  32  store data.
REQ-007 busReadData  output  32  combinational read of the addressed register; 0 for unmapped addresses.
REQ-008 trapTaken  input  1  core has taken the trap this cycle (controller isTrap).
REQ-009 trapReturn  input  1  handler exit, MRET-equivalent, one-cycle pulse.
REQ-010 timerInterrupt  output  1  level interrupt request to the controller.
REQ-011 TIMER_BASE  parameter, default 32'h0000_4000  register-block base address.

Function
REQ-012 The register map SHALL be word-aligned offsets from TIMER_BASE: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 enable), 0x14 PRESCALE (bits 7:0).
REQ-013 A register SHALL be written when busWriteEnable=1 and busAddress matches its address exactly; other addresses SHALL be ignored.
REQ-014 The 8-bit prescale counter SHALL increment every cycle while enable=1; when it equals PRESCALE it SHALL wrap to 0 and generate a tick that same cycle.
REQ-015 With PRESCALE=0, the 64-bit mtime SHALL increment every cycle while enable=1.
REQ-016 mtime SHALL wrap from 2^64-1 to 0 with no flag.
REQ-017 A bus write to MTIME_LO/HI SHALL take precedence over a tick in the same cycle; only the written half SHALL change, and the other half SHALL hold.
REQ-018 Writing PRESCALE or CTRL SHALL clear the prescale counter.
REQ-019 The compare condition SHALL be: enable=1 and mtime >= mtimecmp, 64-bit unsigned, evaluated on registered values.
REQ-020 The block SHALL implement the FSM states DISARMED, ARMED, PENDING and INSERVICE.
REQ-021 Transition DISARMED->ARMED SHALL occur on a write of enable=1; a write of enable=0 from any state SHALL go to DISARMED.
REQ-022 Transition ARMED->PENDING SHALL occur in the cycle after the compare condition is true.
REQ-023 Transition PENDING->INSERVICE SHALL occur on trapTaken=1.
REQ-024 Transition PENDING->ARMED SHALL occur on an MTIMECMP write that makes the compare condition false.
REQ-025 Transition INSERVICE->ARMED SHALL occur on trapReturn=1.
REQ-026 If the compare condition is still true after the INSERVICE->ARMED transition, ARMED SHALL move to PENDING on the next cycle.
REQ-027 In INSERVICE, compare matches SHALL be ignored; there is no nesting.
REQ-028 timerInterrupt SHALL be a registered decode of state==PENDING with no combinational path from any input.
REQ-029 Latency from mtime==mtimecmp becoming visible to timerInterrupt=1 SHALL be exactly 1 cycle.
REQ-030 timerInterrupt SHALL drop in the cycle after trapTaken is sampled.
REQ-031 trapTaken outside PENDING and trapReturn outside INSERVICE SHALL be ignored.
REQ-032 If trapTaken coincides with an MTIMECMP write in PENDING, trapTaken SHALL win.
REQ-033 If trapReturn coincides with an MTIMECMP write in INSERVICE, the state SHALL go to ARMED and the compare SHALL use the new value.

Reset
REQ-034 Reset SHALL set: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, prescale counter=0, state=DISARMED, timerInterrupt=0.
REQ-035 Reset asserted mid-operation, including in PENDING or INSERVICE, SHALL force those values immediately, independent of clk.

Structure
REQ-036 The register offsets, the FSM state enum and the default TIMER_BASE SHALL live in shared package timer_pkg.
REQ-037 The prescaler plus 64-bit counter SHALL be a single sub-module, timer_counter (tick, load-lo/hi, mtime out); the FSM and register decode SHALL stay in machine_timer.

Verification
REQ-038 Basic match: PRESCALE=0, MTIMECMP=10, enable=1 -> timerInterrupt rises 1 cycle after mtime reads 10; read MTIME_LO returns 10 at that edge.
REQ-039 Prescaler: PRESCALE=3, enable=1 for 40 cycles -> mtime=10; MTIMECMP_LO=5 -> interrupt after mtime hits 5 (about 20 cycles plus 1).
REQ-040 Handshake: in PENDING pulse trapTaken -> timerInterrupt low next cycle; pulse trapReturn with mtime>=mtimecmp -> interrupt re-asserts 2 cycles later.
REQ-041 Re-arm: in PENDING write MTIMECMP_LO = mtime+100 -> interrupt low next cycle, re-asserts exactly 101 cycles after the write's visible mtime.
REQ-042 Collision/wrap: MTIME_LO=32'hFFFF_FFFF write coincides with tick -> mtime=0x0_FFFF_FFFF; next tick -> 0x1_0000_0000; rst_n low while PENDING -> interrupt 0 and all registers at reset values without a clock edge.
